// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one AES core between NUM_REQ requesters,
// with ld/done sequencing, a WAIT-state watchdog and a one-cycle core recovery reset.
module aes_core_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [NUM_REQ*128-1:0]     i_req_key,
    input  logic [NUM_REQ*128-1:0]     i_req_text,
    output logic [NUM_REQ-1:0]         o_req_ready,
    output logic [NUM_REQ-1:0]         o_resp_valid,
    output logic [127:0]               o_resp_data,
    output logic                       o_resp_err,
    output logic                       o_busy,
    output logic [IDX_W-1:0]           o_grant_idx,
    output logic                       o_core_ld,
    output logic [127:0]               o_core_key,
    output logic [127:0]               o_core_text_in,
    output logic                       o_core_rst_n,
    input  logic                       i_core_done,
    input  logic [127:0]               i_core_text_out
);

    localparam int unsigned DATA_W = 128;
    localparam int unsigned WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]          r_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_grant_idx;
    logic                r_core_ld;
    logic [DATA_W-1:0]   r_core_key;
    logic [DATA_W-1:0]   r_core_text_in;
    logic [WCNT_W-1:0]   r_wcnt;
    logic [NUM_REQ-1:0]  r_resp_valid;
    logic [DATA_W-1:0]   r_resp_data;
    logic                r_resp_err;
    logic                r_core_rst_n;
    logic                r_busy;

    logic [1:0]          w_state_nxt;
    logic [IDX_W-1:0]    w_ptr_nxt;
    logic [IDX_W-1:0]    w_grant_nxt;
    logic                w_ld_nxt;
    logic [DATA_W-1:0]   w_key_nxt;
    logic [DATA_W-1:0]   w_text_nxt;
    logic [WCNT_W-1:0]   w_wcnt_nxt;
    logic [NUM_REQ-1:0]  w_resp_valid_nxt;
    logic [DATA_W-1:0]   w_resp_data_nxt;
    logic                w_resp_err_nxt;
    logic                w_core_rst_n_nxt;
    logic                w_busy_nxt;

    logic                w_found;
    logic [IDX_W-1:0]    w_winner;
    int unsigned         w_best;
    int unsigned         w_dist;
    logic [NUM_REQ-1:0]  w_win_onehot;
    logic [NUM_REQ-1:0]  w_grant_onehot;
    logic [DATA_W-1:0]   w_sel_key;
    logic [DATA_W-1:0]   w_sel_text;

    // Winner is the valid requester at the smallest rotational distance from ptr.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_best   = NUM_REQ;
        w_dist   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_dist = (i + NUM_REQ - 32'(r_ptr)) % NUM_REQ;
            if (i_req_valid[i] && (w_dist < w_best)) begin
                w_best   = w_dist;
                w_winner = IDX_W'(i);
                w_found  = 1'b1;
            end
        end
    end

    always_comb begin
        w_win_onehot   = '0;
        w_grant_onehot = '0;
        w_sel_key      = '0;
        w_sel_text     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_win_onehot[i]   = (IDX_W'(i) == w_winner);
            w_grant_onehot[i] = (IDX_W'(i) == r_grant_idx);
            if (IDX_W'(i) == w_winner) begin
                w_sel_key  = i_req_key[i*DATA_W +: DATA_W];
                w_sel_text = i_req_text[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_ptr_nxt        = r_ptr;
        w_grant_nxt      = r_grant_idx;
        w_ld_nxt         = 1'b0;
        w_key_nxt        = r_core_key;
        w_text_nxt       = r_core_text_in;
        w_wcnt_nxt       = r_wcnt;
        w_resp_valid_nxt = '0;
        w_resp_data_nxt  = r_resp_data;
        w_resp_err_nxt   = r_resp_err;
        w_core_rst_n_nxt = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_key_nxt   = w_sel_key;
                    w_text_nxt  = w_sel_text;
                    w_grant_nxt = w_winner;
                    w_ld_nxt    = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_wcnt_nxt  = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (i_core_done) begin
                    w_resp_data_nxt  = i_core_text_out;
                    w_resp_err_nxt   = 1'b0;
                    w_resp_valid_nxt = w_grant_onehot;
                    w_state_nxt      = S_RESP;
                end else if (r_wcnt == WCNT_W'(TIMEOUT - 1)) begin
                    w_resp_data_nxt  = '0;
                    w_resp_err_nxt   = 1'b1;
                    w_resp_valid_nxt = w_grant_onehot;
                    w_core_rst_n_nxt = 1'b0;
                    w_state_nxt      = S_RESP;
                end else begin
                    w_wcnt_nxt = r_wcnt + WCNT_W'(1);
                end
            end
            S_RESP: begin
                w_ptr_nxt   = IDX_W'((32'(r_grant_idx) + 32'd1) % NUM_REQ);
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_ptr          <= '0;
            r_grant_idx    <= '0;
            r_core_ld      <= 1'b0;
            r_core_key     <= '0;
            r_core_text_in <= '0;
            r_wcnt         <= '0;
            r_resp_valid   <= '0;
            r_resp_data    <= '0;
            r_resp_err     <= 1'b0;
            r_core_rst_n   <= 1'b1;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_ptr          <= w_ptr_nxt;
            r_grant_idx    <= w_grant_nxt;
            r_core_ld      <= w_ld_nxt;
            r_core_key     <= w_key_nxt;
            r_core_text_in <= w_text_nxt;
            r_wcnt         <= w_wcnt_nxt;
            r_resp_valid   <= w_resp_valid_nxt;
            r_resp_data    <= w_resp_data_nxt;
            r_resp_err     <= w_resp_err_nxt;
            r_core_rst_n   <= w_core_rst_n_nxt;
            r_busy         <= w_busy_nxt;
        end
    end

    // Accept strobe and core reset are the only combinational outputs; both are gated by rst.
    assign o_req_ready    = (r_state == S_IDLE && !i_rst && w_found) ? w_win_onehot : '0;
    assign o_core_rst_n   = r_core_rst_n & ~i_rst;
    assign o_resp_valid   = r_resp_valid;
    assign o_resp_data    = r_resp_data;
    assign o_resp_err     = r_resp_err;
    assign o_busy         = r_busy;
    assign o_grant_idx    = r_grant_idx;
    assign o_core_ld      = r_core_ld;
    assign o_core_key     = r_core_key;
    assign o_core_text_in = r_core_text_in;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Randomized bench for aes_core_arbiter: stub core (key^text after 12 cycles) and a
// transaction-level round-robin model predicting grant order, latency and response.
module tb_aes_core_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned IW  = 2;
    localparam int unsigned TO  = 64;
    localparam int unsigned LAT = 12;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [N*128-1:0]   req_key;
    logic [N*128-1:0]   req_text;
    logic [N-1:0]       req_ready;
    logic [N-1:0]       resp_valid;
    logic [127:0]       resp_data;
    logic               resp_err;
    logic               busy;
    logic [IW-1:0]      grant_idx;
    logic               core_ld;
    logic [127:0]       core_key;
    logic [127:0]       core_text_in;
    logic               core_rst_n;
    logic               core_done;
    logic [127:0]       core_text_out;

    always #5 clk = ~clk;

    aes_core_arbiter #(.NUM_REQ(N), .IDX_W(IW), .TIMEOUT(TO)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .i_req_key(req_key), .i_req_text(req_text),
        .o_req_ready(req_ready), .o_resp_valid(resp_valid), .o_resp_data(resp_data),
        .o_resp_err(resp_err), .o_busy(busy), .o_grant_idx(grant_idx),
        .o_core_ld(core_ld), .o_core_key(core_key), .o_core_text_in(core_text_in),
        .o_core_rst_n(core_rst_n), .i_core_done(core_done), .i_core_text_out(core_text_out)
    );

    // Stub core: done 12 cycles after ld is sampled; hang suppresses it, hold stretches it to 3 cycles.
    bit           hang = 1'b0;
    bit           hold = 1'b0;
    int           age  = 0;
    logic [127:0] stub_out = '0;

    always @(posedge clk) begin
        if (!core_rst_n) begin
            age <= 0;
        end else if (core_ld) begin
            age      <= 1;
            stub_out <= core_key ^ core_text_in;
        end else if (age != 0 && age < 255) begin
            age <= age + 1;
        end
    end

    assign core_done     = !hang && (hold ? (age >= 12 && age <= 14) : (age == 12));
    assign core_text_out = stub_out;

    logic [127:0] m_key  [N];
    logic [127:0] m_text [N];
    logic [N-1:0] m_valid;
    int           m_ptr;
    int           cyc = 0;
    int           checks = 0;
    int           failures = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #2;
    endtask

    task automatic drive_reqs();
        req_valid = m_valid;
        for (int i = 0; i < N; i++) begin
            req_key[i*128 +: 128]  = m_key[i];
            req_text[i*128 +: 128] = m_text[i];
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic new_req(input int i);
        m_key[i]   = rand128();
        m_text[i]  = rand128();
        m_valid[i] = 1'b1;
        drive_reqs();
    endtask

    function automatic int model_winner();
        for (int k = 0; k < N; k++) begin
            if (m_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic quiet_window(input string tag, input int ncyc);
        int seen = 0;
        for (int k = 0; k < ncyc; k++) begin
            tick();
            if (resp_valid != '0) seen++;
        end
        check(tag, seen, 0);
    endtask

    // One full operation: accept, load, wait, respond, return to IDLE.
    task automatic serve_one(input bit exp_err, output int w_obs, output int t_acc);
        int           w;
        int           guard;
        bit           key_ok;
        bit           rstn_ok;
        logic [127:0] ek;
        logic [127:0] et;
        logic [N-1:0] exp_rdy;
        w_obs = -1;
        t_acc = cyc;
        #1;
        guard = 0;
        while (req_ready == '0 && guard < 50) begin
            tick();
            guard++;
        end
        w       = model_winner();
        exp_rdy = (w < 0) ? '0 : N'(1) << w;
        check("req_ready", req_ready, exp_rdy);
        if (w < 0 || guard >= 50) return;
        ek    = m_key[w];
        et    = m_text[w];
        t_acc = cyc;
        tick();
        m_valid[w] = 1'b0;
        drive_reqs();
        w_obs = int'(grant_idx);
        check("load_ld", core_ld, 1);
        check("load_grant", grant_idx, w);
        check("load_busy", busy, 1);
        check("load_key", core_key, ek);
        check("load_text", core_text_in, et);
        tick();
        check("ld_pulse", core_ld, 0);
        key_ok  = 1'b1;
        rstn_ok = 1'b1;
        guard   = 0;
        while (resp_valid == '0 && guard < 100) begin
            if (core_key !== ek || core_text_in !== et) key_ok = 1'b0;
            if (core_rst_n !== 1'b1) rstn_ok = 1'b0;
            tick();
            guard++;
        end
        check("latency", cyc - t_acc, exp_err ? TO + 2 : LAT + 2);
        check("resp_valid", resp_valid, N'(1) << w);
        check("resp_err", resp_err, exp_err);
        check("resp_data", resp_data, exp_err ? 128'd0 : (ek ^ et));
        check("resp_core_rst_n", core_rst_n, !exp_err);
        check("key_stable", key_ok && core_key === ek && core_text_in === et, 1);
        check("core_rst_n_wait", rstn_ok, 1);
        m_ptr = (w + 1) % N;
        tick();
        check("idle_busy", busy, 0);
        check("idle_resp_valid", resp_valid, 0);
        check("idle_core_rst_n", core_rst_n, 1);
        check("resp_data_held", resp_data, exp_err ? 128'd0 : (ek ^ et));
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        #1;
        check("rst_core_rst_n", core_rst_n, 0);
        for (int k = 0; k < ncyc; k++) tick();
        check("rst_core_rst_n_hold", core_rst_n, 0);
        check("rst_outputs", {req_ready, resp_valid, resp_err, busy, grant_idx, core_ld}, 0);
        check("rst_core_key", core_key | core_text_in, 0);
        check("rst_resp_data", resp_data, 0);
        rst   = 1'b0;
        m_ptr = 0;
        tick();
        check("post_rst_core_rst_n", core_rst_n, 1);
    endtask

    initial begin
        int w;
        int t;
        int tprev;
        rst     = 1'b1;
        m_valid = '0;
        for (int i = 0; i < N; i++) begin
            m_key[i]  = '0;
            m_text[i] = '0;
        end
        drive_reqs();
        do_reset(3);

        // Single request with the reference vector.
        m_key[0]   = 128'hcafebabedeadbeefdeadbeef00000000;
        m_text[0]  = 128'hB9648E3DC1F30548DAD060FCDADF5035;
        m_valid[0] = 1'b1;
        drive_reqs();
        serve_one(1'b0, w, t);

        // Round-robin from reset: every requester re-presents after being served.
        do_reset(1);
        for (int i = 0; i < N; i++) new_req(i);
        tprev = 0;
        for (int k = 0; k < 5; k++) begin
            serve_one(1'b0, w, t);
            check("rr_order", w, k % N);
            if (k > 0) check("rr_spacing", t - tprev, LAT + 3);
            tprev = t;
            new_req(w);
        end

        // Pointer skip: after serving 1, requester 3 wins over 0.
        m_valid = '0;
        drive_reqs();
        new_req(1);
        serve_one(1'b0, w, t);
        new_req(0);
        new_req(3);
        serve_one(1'b0, w, t);
        check("skip_first", w, 3);
        serve_one(1'b0, w, t);
        check("skip_second", w, 0);

        // Watchdog timeout, then a normal operation.
        hang = 1'b1;
        new_req(2);
        serve_one(1'b1, w, t);
        hang = 1'b0;
        new_req(2);
        serve_one(1'b0, w, t);

        // Held done level produces a single response.
        hold = 1'b1;
        new_req(3);
        serve_one(1'b0, w, t);
        quiet_window("hold_single_resp", 20);
        hold = 1'b0;

        // Reset in the middle of WAIT drops the operation and clears ptr.
        new_req(1);
        serve_one(1'b0, w, t);
        new_req(2);
        #1;
        check("mid_accept", req_ready, 4'b0100);
        tick();
        m_valid = '0;
        drive_reqs();
        for (int k = 0; k < 6; k++) tick();
        check("mid_busy", busy, 1);
        do_reset(1);
        quiet_window("mid_no_resp", 20);
        for (int i = 0; i < N; i++) new_req(i);
        serve_one(1'b0, w, t);
        check("mid_ptr_reset", w, 0);

        // Randomized traffic with occasional hangs and requesters withdrawing.
        for (int op = 0; op < 40; op++) begin
            for (int i = 0; i < N; i++) begin
                if (!m_valid[i] && $urandom_range(0, 1) == 1) new_req(i);
                else if (m_valid[i] && $urandom_range(0, 3) == 0) m_valid[i] = 1'b0;
            end
            if (m_valid == '0) new_req(int'($urandom_range(0, N - 1)));
            drive_reqs();
            hang = ($urandom_range(0, 7) == 0);
            serve_one(hang, w, t);
            hang = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Shares one aes_cipher_top encryption core between NUM_REQ independent requesters.
- Arbitrates round-robin and hands the winner's key and plaintext to the core.
- Sequences the core's ld/done protocol and returns the ciphertext to the winning requester.
- Sits between the requester-side buses and the single core instance. It also supervises the core with a timeout watchdog and a recovery reset.

Parameters:
- NUM_REQ, 4: number of requesters; 2..16.
- IDX_W, 2: width of the granted index; must be ≥ ceil(log2(NUM_REQ)).
- TIMEOUT, 64: maximum number of WAIT cycles before the operation is aborted.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request. Once raised, it is held along with its data until accepted.
- req_key  in  NUM_REQ*128  per-requester key; slice i is bits [128*i+127:128*i].
- req_text  in  NUM_REQ*128  per-requester plaintext, sliced the same way.
- req_ready  out  NUM_REQ  one-hot accept strobe; a request transfers when req_valid[i] and req_ready[i] are both high.
- resp_valid  out  NUM_REQ  one-hot, one-cycle result strobe to the original requester.
- resp_data  out  128  ciphertext; valid while resp_valid is nonzero and held until the next response.
- resp_err  out  1  qualifies resp_valid; 1 means the operation timed out and resp_data is 0.
- busy  out  1  high in every state except IDLE.
- grant_idx  out  IDX_W  index of the current or last-served requester.
- core_ld  out  1  one-cycle load strobe to the core.
- core_key  out  128  key to the core; registered and stable from LOAD through RESP.
- core_text_in  out  128  plaintext to the core; registered and stable from LOAD through RESP.
- core_rst_n  out  1  active-low reset to the core.
- core_done  in  1  completion from the core; may be a pulse or a level.
- core_text_out  in  128  ciphertext from the core.

Behaviour:
- Reset values: state=IDLE, ptr=0, grant_idx=0, and every other output 0. The single exception is core_rst_n, which is 0 during rst and goes to 1 on the first cycle after rst deasserts.
- rst asserted in any state aborts the operation with no response. Any in-flight request is dropped and must be re-presented.
- State machine: IDLE → LOAD → WAIT → RESP → IDLE.
- IDLE, winner selection: the winner is the first i with req_valid[i]=1, scanning ptr, ptr+1, … modulo NUM_REQ.
- IDLE, accept cycle: req_ready[winner]=1 combinationally, only while state=IDLE.
  - On that edge, capture req_key/req_text into core_key/core_text_in.
  - Set grant_idx=winner and go to LOAD.
  - With no valid request, stay in IDLE and keep req_ready at 0.
- LOAD: core_ld=1 for exactly one cycle; clear the watchdog counter wcnt; go to WAIT.
- WAIT: core_done=1 captures core_text_out into resp_data, sets resp_err=0 and goes to RESP.
  - core_done seen in LOAD is ignored.
  - Otherwise wcnt increments.
  - When wcnt==TIMEOUT-1 without done: resp_data=0, resp_err=1, core_rst_n=0 for exactly one cycle (the RESP cycle), then go to RESP.
  - If done and timeout coincide, done wins.
- RESP: resp_valid[grant_idx]=1 for one cycle; ptr=(grant_idx+1) mod NUM_REQ; go to IDLE.
- Latency: accept at cycle T, core_ld at T+1, core_done at T+1+L, resp_valid at T+2+L. The earliest next accept is T+3+L.
- Fairness: a requester that stays valid is served within NUM_REQ operations.
- req_valid dropping before acceptance is legal and is simply not granted.
- req_valid changes in LOAD, WAIT or RESP have no effect on the current operation.
- core_key and core_text_in never change between accept and the exit from RESP, so the core's on-the-fly key expansion sees a stable key.

Test Plan:
Bench uses a stub core: when core_ld is sampled high, it asserts core_done for one cycle 12 cycles later with core_text_out = key ^ text. A hang mode suppresses done.
- Single request: req_valid=4'b0001, key=128'hcafebabedeadbeefdeadbeef00000000, text=128'hB9648E3DC1F30548DAD060FCDADF5035, accept at cycle 0 → core_ld at cycle 1, resp_valid=4'b0001 at cycle 14, resp_data = key^text, resp_err=0, busy low at cycle 15.
- Round-robin: all four valid from reset, distinct keys → grant order 0,1,2,3,0; req_ready pulses are 15 cycles apart; each resp_data matches its own key^text.
- Pointer skip: after serving 1, only requesters 0 and 3 valid → 3 is granted before 0.
- Timeout: stub in hang mode, TIMEOUT=64 → resp_valid at 64 WAIT cycles after LOAD, resp_err=1, resp_data=0, core_rst_n low for exactly that cycle; a next request then completes normally.
- Reset mid-operation: assert rst for one cycle at WAIT cycle 5 → no resp_valid, all outputs 0, core_rst_n low during rst; after release, requester 0 is re-granted first (ptr=0).
- Late done level: stub holds core_done high for 3 cycles → exactly one resp_valid; the held level is not seen as a second completion.
